// File: rtl/savestate_ctrl.sv
// Savestate controller: accepts save/load requests for one of four slots,
// pauses the core, kicks the savestate engine at the slot base address,
// resumes the core and reports the outcome as a one-cycle info code.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for ss_save/ss_load; only state that accepts one
// S_PAUSE  | pause_req high, waiting for core_paused (with timeout)
// S_START  | one-cycle eng_save/eng_load pulse
// S_WAIT   | waiting for eng_done/eng_err (with timeout)
// S_RESUME | pause_req low, waiting for core_paused to drop (no timeout)
// S_REPORT | one-cycle info_req strobe carrying the pending code
module savestate_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                SLOT_SHIFT   = 20,
  parameter int                TIMEOUT_BITS = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ss_save,
  input  logic              ss_load,
  input  logic [1:0]        slot,
  input  logic [3:0]        valid_init,
  input  logic              valid_init_we,
  input  logic              core_paused,
  input  logic              eng_done,
  input  logic              eng_err,
  output logic              pause_req,
  output logic              eng_save,
  output logic              eng_load,
  output logic [ADDR_W-1:0] ss_addr,
  output logic              busy,
  output logic              info_req,
  output logic [7:0]        info,
  output logic [3:0]        slot_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_START,
    S_WAIT,
    S_RESUME,
    S_REPORT
  } state_t;

  localparam logic [7:0] CODE_TIMEOUT = 8'd28;
  localparam logic [7:0] CODE_ENG_ERR = 8'd29;

  state_t                  state, state_nxt;
  logic                    op_load;
  logic [1:0]              slot_q;
  logic [7:0]              code_q, code_nxt;
  logic [TIMEOUT_BITS-1:0] cnt, cnt_inc;
  logic                    tmo;
  logic                    accept, req_load, valid_set;
  logic [3:0]              set_mask;
  logic [ADDR_W-1:0]       addr_nxt;

  // The timeout fires on the cycle the wait counter would roll into its MSB.
  assign cnt_inc  = cnt + TIMEOUT_BITS'(1);
  assign tmo      = cnt_inc[TIMEOUT_BITS-1];
  assign addr_nxt = BASE_ADDR + (ADDR_W'(slot) << SLOT_SHIFT);
  assign set_mask = valid_set ? (4'b0001 << slot_q) : 4'b0000;
  assign busy     = (state != S_IDLE);

  // Next-state, pending result code and the combinational handshake outputs.
  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    accept    = 1'b0;
    req_load  = 1'b0;
    valid_set = 1'b0;
    pause_req = 1'b0;
    eng_save  = 1'b0;
    eng_load  = 1'b0;
    info_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ss_save || ss_load) begin
          accept   = 1'b1;
          req_load = !ss_save;
          if (req_load && !slot_valid[slot]) begin
            state_nxt = S_REPORT;
            code_nxt  = 8'd24 + {6'd0, slot};
          end else begin
            state_nxt = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        pause_req = 1'b1;
        if (core_paused) begin
          state_nxt = S_START;
        end else if (tmo) begin
          state_nxt = S_RESUME;
          code_nxt  = CODE_TIMEOUT;
        end
      end
      S_START: begin
        pause_req = 1'b1;
        eng_save  = !op_load;
        eng_load  = op_load;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        pause_req = 1'b1;
        if (eng_err) begin
          state_nxt = S_RESUME;
          code_nxt  = CODE_ENG_ERR;
        end else if (eng_done) begin
          state_nxt = S_RESUME;
          code_nxt  = 8'd16 + {5'd0, slot_q, op_load};
          valid_set = !op_load;
        end else if (tmo) begin
          state_nxt = S_RESUME;
          code_nxt  = CODE_TIMEOUT;
        end
      end
      S_RESUME: begin
        if (!core_paused) state_nxt = S_REPORT;
      end
      S_REPORT: begin
        info_req  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Wait counter: restarts on every state change, runs only in PAUSE and WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cnt <= '0;
    else if (state_nxt != state)                 cnt <= '0;
    else if (state == S_PAUSE || state == S_WAIT) cnt <= cnt_inc;
  end

  // Request latches, pending code and the info value presented on entry to REPORT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_load <= 1'b0;
      slot_q  <= 2'd0;
      ss_addr <= '0;
      code_q  <= 8'd0;
      info    <= 8'd0;
    end else begin
      if (accept) begin
        op_load <= req_load;
        slot_q  <= slot;
        ss_addr <= addr_nxt;
      end
      code_q <= code_nxt;
      if (state_nxt == S_REPORT && state != S_REPORT) info <= code_nxt;
    end
  end

  // Slot validity: preset write wins over old contents, a successful save ORs its bit in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              slot_valid <= 4'b0000;
    else if (valid_init_we) slot_valid <= valid_init | set_mask;
    else                    slot_valid <= slot_valid | set_mask;
  end

endmodule

// File: tb/tb_savestate_ctrl.sv
// Testbench for savestate_ctrl: hand-checked vector table, randomized
// operations against a transaction-level model, and corner-case sequences.
module tb_savestate_ctrl;

  localparam int          TB_MAIN   = 6;
  localparam int          TB_SMALL  = 4;
  localparam logic [31:0] BASE_MAIN = 32'h0000_0000;
  localparam logic [31:0] BASE_SMALL = 32'hFFF0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ss_save, ss_load;
  logic [1:0]  slot;
  logic [3:0]  valid_init;
  logic        valid_init_we;
  logic        core_paused, eng_done, eng_err;

  logic        pause_req, eng_save, eng_load, busy, info_req;
  logic [31:0] ss_addr;
  logic [7:0]  info;
  logic [3:0]  slot_valid;

  logic        pause_req2, eng_save2, eng_load2, busy2, info_req2;
  logic [31:0] ss_addr2;
  logic [7:0]  info2;
  logic [3:0]  slot_valid2;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  mvalid;

  savestate_ctrl #(.ADDR_W(32), .BASE_ADDR(BASE_MAIN), .SLOT_SHIFT(20), .TIMEOUT_BITS(TB_MAIN)) dut (
    .clk(clk), .reset(reset), .ss_save(ss_save), .ss_load(ss_load), .slot(slot),
    .valid_init(valid_init), .valid_init_we(valid_init_we), .core_paused(core_paused),
    .eng_done(eng_done), .eng_err(eng_err), .pause_req(pause_req), .eng_save(eng_save),
    .eng_load(eng_load), .ss_addr(ss_addr), .busy(busy), .info_req(info_req), .info(info),
    .slot_valid(slot_valid)
  );

  savestate_ctrl #(.ADDR_W(32), .BASE_ADDR(BASE_SMALL), .SLOT_SHIFT(20), .TIMEOUT_BITS(TB_SMALL)) dut_small (
    .clk(clk), .reset(reset), .ss_save(ss_save), .ss_load(ss_load), .slot(slot),
    .valid_init(valid_init), .valid_init_we(valid_init_we), .core_paused(core_paused),
    .eng_done(eng_done), .eng_err(eng_err), .pause_req(pause_req2), .eng_save(eng_save2),
    .eng_load(eng_load2), .ss_addr(ss_addr2), .busy(busy2), .info_req(info_req2), .info(info2),
    .slot_valid(slot_valid2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic       ld;
    logic [1:0] sl;
    int         pdly;   // cycles of pause_req before core_paused rises, -1 = never
    int         hold;   // cycles core_paused lingers after pause_req falls
    int         resp;   // 0 done, 1 err, 2 no response
    int         rdly;
    int         wi;     // valid_init value written alongside the engine response, -1 = none
    bit         spam;
    logic [7:0] exp_code;
    logic [3:0] exp_valid;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ss_save = 0; ss_load = 0; slot = 0; valid_init = 0; valid_init_we = 0;
    core_paused = 0; eng_done = 0; eng_err = 0;
    mvalid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preset(input logic [3:0] v);
    @(negedge clk);
    valid_init = v; valid_init_we = 1'b1; mvalid = v;
    @(negedge clk);
    valid_init_we = 1'b0;
    chk("preset slot_valid", {28'd0, slot_valid}, {28'd0, v});
  endtask

  // Drives one request, plays the core and engine, and checks the outcome
  // against a transaction-level view of what the request should produce.
  task automatic run_op(input string tag, input logic sv, input logic ld, input logic [1:0] sl,
                        input int pdly, input int hold, input int resp, input int rdly,
                        input int wi, input bit spam, output logic [7:0] got_code);
    bit          is_load, e_pause, e_eng, done, was_paused, idle_bad;
    int          e_code;
    logic [31:0] e_addr, got_addr;
    int          n_sv, n_ld, ph, hl, edly, cyc, pause_at, eng_at, fall_at, info_at;

    is_load = ld && !sv;
    e_addr  = BASE_MAIN + (32'(sl) << 20);
    e_pause = !(is_load && !mvalid[sl]);
    e_eng   = 1'b0;
    if (!e_pause)      e_code = 24 + int'(sl);
    else if (pdly < 0) e_code = 28;
    else begin
      e_eng = 1'b1;
      if (resp == 0)      e_code = 16 + 2 * int'(sl) + (is_load ? 1 : 0);
      else if (resp == 1) e_code = 29;
      else                e_code = 28;
      if (resp < 2 && wi >= 0) mvalid = wi[3:0];
      if (resp == 0 && !is_load) mvalid[sl] = 1'b1;
    end

    n_sv = 0; n_ld = 0; ph = 0; hl = 0; edly = -1; cyc = 0;
    pause_at = -1; eng_at = -1; fall_at = -1; info_at = -1;
    done = 0; was_paused = 0; got_code = 8'd0; got_addr = 32'd0;
    core_paused = 0; eng_done = 0; eng_err = 0; valid_init_we = 0;

    @(negedge clk);
    ss_save = sv; ss_load = ld; slot = sl;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ss_save = 0; ss_load = 0; eng_done = 0; eng_err = 0; valid_init_we = 0;
      if (eng_save) n_sv++;
      if (eng_load) n_ld++;
      if (pause_req) begin
        if (pause_at < 0) pause_at = cyc;
        ph++;
        if (pdly >= 0 && ph > pdly) begin core_paused = 1; was_paused = 1; end
      end else begin
        if (pause_at >= 0 && fall_at < 0) fall_at = cyc;
        if (core_paused) begin
          if (hl >= hold) core_paused = 0;
          else hl++;
        end
      end
      if ((eng_save || eng_load) && eng_at < 0) begin
        eng_at = cyc;
        if (resp < 2) edly = rdly;
      end else if (edly == 0) begin
        if (resp == 0) eng_done = 1; else eng_err = 1;
        if (wi >= 0) begin valid_init = wi[3:0]; valid_init_we = 1; end
        edly = -1;
      end else if (edly > 0) begin
        edly--;
      end
      if (spam && eng_at >= 0 && cyc == eng_at + 1) begin ss_save = 1; ss_load = 1; end
      if (info_req) begin
        info_at  = cyc;
        got_code = info;
        got_addr = ss_addr;
        if (spam) begin ss_save = 1; ss_load = 1; end
        done = 1;
      end
    end
    chk({tag, " completes"}, 32'(done), 32'd1);
    idle_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ss_save = 0; ss_load = 0; valid_init_we = 0; eng_done = 0; eng_err = 0; core_paused = 0;
      if (busy || info_req || pause_req || info !== got_code) idle_bad = 1;
    end
    chk({tag, " idle after report"}, 32'(idle_bad), 32'd0);
    chk({tag, " code"}, 32'(got_code), 32'(e_code));
    chk({tag, " addr"}, got_addr, e_addr);
    chk({tag, " eng_save pulses"}, 32'(n_sv), (e_eng && !is_load) ? 32'd1 : 32'd0);
    chk({tag, " eng_load pulses"}, 32'(n_ld), (e_eng && is_load) ? 32'd1 : 32'd0);
    chk({tag, " paused"}, 32'(pause_at >= 0), 32'(e_pause));
    chk({tag, " slot_valid"}, {28'd0, slot_valid}, {28'd0, mvalid});
    if (!e_pause) chk({tag, " reject latency"}, 32'(info_at), 32'd1);
    else begin
      chk({tag, " pause latency"}, 32'(pause_at), 32'd1);
      chk({tag, " report latency"}, 32'(info_at - fall_at), 32'(1 + (was_paused ? hold : 0)));
      if (pdly < 0) chk({tag, " pause timeout"}, 32'(ph), 32'(2 ** (TB_MAIN - 1)));
      else          chk({tag, " start latency"}, 32'(eng_at), 32'(pause_at + pdly + 1));
      if (e_eng && resp == 2)
        chk({tag, " wait timeout"}, 32'(fall_at - eng_at), 32'(2 ** (TB_MAIN - 1) + 1));
    end
  endtask

  initial begin
    vec_t       vecs[12];
    logic [7:0] code;
    int         ph, n, info_at, fall_at;
    logic [31:0] addr;
    bit         found;

    reset = 1'b1;
    ss_save = 0; ss_load = 0; slot = 0; valid_init = 0; valid_init_we = 0;
    core_paused = 0; eng_done = 0; eng_err = 0; mvalid = 0;

    vecs[0]  = '{0, 1, 1,  0, 0, 0,  0, -1, 0, 8'd25, 4'b0000};
    vecs[1]  = '{1, 0, 2,  3, 1, 0, 10, -1, 0, 8'd20, 4'b0100};
    vecs[2]  = '{0, 1, 2,  1, 0, 0,  2, -1, 1, 8'd21, 4'b0100};
    vecs[3]  = '{1, 0, 3,  0, 0, 1,  1, -1, 0, 8'd29, 4'b0100};
    vecs[4]  = '{0, 1, 3,  0, 0, 0,  0, -1, 0, 8'd27, 4'b0100};
    vecs[5]  = '{1, 0, 0,  2, 0, 0,  0, -1, 0, 8'd16, 4'b0101};
    vecs[6]  = '{1, 1, 3,  0, 0, 0,  3, -1, 1, 8'd22, 4'b1101};
    vecs[7]  = '{0, 1, 3,  0, 0, 1,  2, -1, 0, 8'd29, 4'b1101};
    vecs[8]  = '{1, 0, 1, -1, 0, 0,  0, -1, 0, 8'd28, 4'b1101};
    vecs[9]  = '{0, 1, 0,  1, 0, 2,  0, -1, 0, 8'd28, 4'b1101};
    vecs[10] = '{1, 0, 1,  0, 0, 0,  1,  8, 0, 8'd18, 4'b1010};
    vecs[11] = '{0, 1, 1,  0, 2, 0,  0, -1, 0, 8'd19, 4'b1010};

    #1;
    chk("reset pause_req", 32'(pause_req), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset info_req", 32'(info_req), 32'd0);
    chk("reset slot_valid", {28'd0, slot_valid}, 32'd0);
    chk("reset ss_addr", ss_addr, 32'd0);
    chk("reset info", 32'(info), 32'd0);
    do_reset();
    preset(4'b0000);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].sv, vecs[i].ld, vecs[i].sl, vecs[i].pdly,
             vecs[i].hold, vecs[i].resp, vecs[i].rdly, vecs[i].wi, vecs[i].spam, code);
      chk($sformatf("vec%0d table code", i), 32'(code), 32'(vecs[i].exp_code));
      chk($sformatf("vec%0d table valid", i), {28'd0, slot_valid}, {28'd0, vecs[i].exp_valid});
    end

    // Pause timeout on the short-timeout instance; slot 1 address wraps past the top.
    do_reset();
    @(negedge clk);
    ss_save = 1; slot = 2'd1;
    ph = 0; n = 0; info_at = -1; fall_at = -1; code = 0; addr = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40 && info_at < 0; c++) begin
      @(negedge clk);
      ss_save = 0;
      if (pause_req2) ph++;
      else if (ph > 0 && fall_at < 0) fall_at = c;
      if (eng_save2 || eng_load2) n++;
      if (info_req2) begin info_at = c; code = info2; addr = ss_addr2; end
    end
    chk("short pause cycles", 32'(ph), 32'd8);
    chk("short eng pulses", 32'(n), 32'd0);
    chk("short timeout code", 32'(code), 32'd28);
    chk("short info latency", 32'(info_at), 32'd10);
    chk("short fall latency", 32'(fall_at), 32'd9);
    chk("short addr wrap", addr, 32'h0000_0000);

    // Reset during WAIT aborts immediately and the next request runs normally.
    do_reset();
    preset(4'b0001);
    @(negedge clk);
    ss_save = 1; slot = 2'd0; core_paused = 1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      ss_save = 0;
      if (eng_save) found = 1;
    end
    chk("abort reached start", 32'(found), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort pause_req", 32'(pause_req), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort info_req", 32'(info_req), 32'd0);
    chk("abort slot_valid", {28'd0, slot_valid}, 32'd0);
    core_paused = 0; mvalid = 4'b0000;
    @(negedge clk);
    chk("abort info_req held", 32'(info_req), 32'd0);
    reset = 1'b0;
    run_op("after abort", 1, 0, 2'd3, 1, 0, 0, 2, -1, 0, code);
    chk("after abort code", 32'(code), 32'd22);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      int op, pd, rs;
      op = $urandom_range(0, 2);
      pd = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
      rs = ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) preset(4'($urandom_range(0, 15)));
      run_op($sformatf("rnd%0d", i), op != 1, op != 0, 2'($urandom_range(0, 3)), pd,
             $urandom_range(0, 2), rs, $urandom_range(0, 6),
             ($urandom_range(0, 6) == 0) ? $urandom_range(0, 15) : -1,
             $urandom_range(0, 4) == 0, code);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
